// File: rtl/ring_stop_if.sv
// Ring stop port bundle: upstream/downstream ring links, injection FIFO head and ejection register.
// RING_STOP_STATS_EN adds the 16-bit statistics outputs to the bundle.
interface ring_stop_if #(
  parameter int WIDTH = 32
);
  logic             iRingVld;
  logic [WIDTH-1:0] iRingDat;
  logic             oRingVld;
  logic [WIDTH-1:0] oRingDat;
  logic             iInjEmpty;
  logic [WIDTH-1:0] iInjDat;
  logic             oInjRdEn;
  logic             oEjVld;
  logic [WIDTH-1:0] oEjDat;
  logic             iEjRdy;
  logic             iThrottle;
  logic             oStarve;
`ifdef RING_STOP_STATS_EN
  logic [15:0]      oStatInj;
  logic [15:0]      oStatEj;
  logic [15:0]      oStatDefl;

  modport master (
    input  iRingVld, iRingDat, iInjEmpty, iInjDat, iEjRdy, iThrottle,
    output oRingVld, oRingDat, oInjRdEn, oEjVld, oEjDat, oStarve,
    output oStatInj, oStatEj, oStatDefl
  );
  modport slave (
    output iRingVld, iRingDat, iInjEmpty, iInjDat, iEjRdy, iThrottle,
    input  oRingVld, oRingDat, oInjRdEn, oEjVld, oEjDat, oStarve,
    input  oStatInj, oStatEj, oStatDefl
  );
`else
  modport master (
    input  iRingVld, iRingDat, iInjEmpty, iInjDat, iEjRdy, iThrottle,
    output oRingVld, oRingDat, oInjRdEn, oEjVld, oEjDat, oStarve
  );
  modport slave (
    output iRingVld, iRingDat, iInjEmpty, iInjDat, iEjRdy, iThrottle,
    input  oRingVld, oRingDat, oInjRdEn, oEjVld, oEjDat, oStarve
  );
`endif
endinterface

// File: rtl/ring_stop.sv
// PtRing NoC station: injects from the local FIFO, ejects own flits, forwards the rest with one cycle latency.
// Optional RING_STOP_STATS_EN adds saturating inject/eject/deflect counters.
module ring_stop #(
  parameter int WIDTH      = 32,
  parameter int ID_W       = 4,
  parameter int NODE_ID    = 0,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  ring_stop_if.master   bus
);
  localparam int CNT_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_MAX - 1);

  typedef enum logic {RUN, STARVED} starveState_t;

  starveState_t     stateReg;
  logic [CNT_W-1:0] countReg;
  logic             starveReg;
  logic             ringVldReg;
  logic [WIDTH-1:0] ringDatReg;
  logic             ejVldReg;
  logic [WIDTH-1:0] ejDatReg;

  logic [ID_W-1:0]  dest;
  logic             match;
  logic             ejSpace;
  logic             eject;
  logic             slotFree;
  logic             injReq;
  logic             inject;

  assign dest     = bus.iRingDat[WIDTH-1 -: ID_W];
  assign match    = bus.iRingVld & (dest == ID_W'(NODE_ID));
  assign ejSpace  = !ejVldReg | bus.iEjRdy;
  assign eject    = match & ejSpace;
  assign slotFree = !bus.iRingVld | eject;
  // A starved stop ignores the ring-wide throttle so it is guaranteed to get a slot.
  assign injReq   = !bus.iInjEmpty & (!bus.iThrottle | starveReg);
  assign inject   = slotFree & injReq;

  assign bus.oInjRdEn = inject & rst;
  assign bus.oRingVld = ringVldReg;
  assign bus.oRingDat = ringDatReg;
  assign bus.oEjVld   = ejVldReg;
  assign bus.oEjDat   = ejDatReg;
  assign bus.oStarve  = starveReg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ringVldReg <= 1'b0;
      ringDatReg <= '0;
      ejVldReg   <= 1'b0;
      ejDatReg   <= '0;
      starveReg  <= 1'b0;
      stateReg   <= RUN;
      countReg   <= '0;
    end else begin
      // Ring slot: our own flit if we took the slot, otherwise pass-through or deflection.
      if (inject) begin
        ringVldReg <= 1'b1;
        ringDatReg <= bus.iInjDat;
      end else if (bus.iRingVld && !eject) begin
        ringVldReg <= 1'b1;
        ringDatReg <= bus.iRingDat;
      end else begin
        ringVldReg <= 1'b0;
      end

      if (eject) begin
        ejVldReg <= 1'b1;
        ejDatReg <= bus.iRingDat;
      end else if (ejVldReg && bus.iEjRdy) begin
        ejVldReg <= 1'b0;
      end

      case (stateReg)
        RUN: begin
          if (bus.iInjEmpty || inject) begin
            countReg <= '0;
          end else if (countReg == CNT_LAST) begin
            stateReg  <= STARVED;
            starveReg <= 1'b1;
          end else begin
            countReg <= countReg + 1'b1;
          end
        end
        STARVED: begin
          if (bus.iInjEmpty || inject) begin
            stateReg  <= RUN;
            starveReg <= 1'b0;
            countReg  <= '0;
          end
        end
        default: stateReg <= RUN;
      endcase
    end
  end

`ifdef RING_STOP_STATS_EN
  logic [15:0] statInjReg;
  logic [15:0] statEjReg;
  logic [15:0] statDeflReg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      statInjReg  <= '0;
      statEjReg   <= '0;
      statDeflReg <= '0;
    end else begin
      if (inject && statInjReg != 16'hFFFF)
        statInjReg <= statInjReg + 16'd1;
      if (eject && statEjReg != 16'hFFFF)
        statEjReg <= statEjReg + 16'd1;
      if (match && !ejSpace && statDeflReg != 16'hFFFF)
        statDeflReg <= statDeflReg + 16'd1;
    end
  end

  assign bus.oStatInj  = statInjReg;
  assign bus.oStatEj   = statEjReg;
  assign bus.oStatDefl = statDeflReg;
`endif
endmodule

// File: tb/tb_ring_stop.sv
// Scoreboard bench for ring_stop (NODE_ID=1, STARVE_MAX=8): directed cycles push expectations,
// a negedge monitor pops and compares them.
module tb_ring_stop;
  localparam logic [31:0] FA = 32'h3000_00AA;  // dest 3
  localparam logic [31:0] FB = 32'h1000_00BB;  // dest 1 (this node)
  localparam logic [31:0] FC = 32'h1000_00CC;  // dest 1 (this node)
  localparam logic [31:0] FD = 32'h5000_00DD;  // dest 5
  localparam logic [31:0] FE = 32'h2000_00EE;  // dest 2
  localparam logic [31:0] FF = 32'h4000_00FF;  // dest 4

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ring_stop_if #(.WIDTH(32)) bus ();

  ring_stop #(
    .WIDTH(32), .ID_W(4), .NODE_ID(1), .STARVE_MAX(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic chkAll;
    logic pop;
    logic starve;
    logic ringV;
    logic zero;
  } ctl_t;

  ctl_t        ctlQ[$];
  logic [31:0] ringQ[$];
  logic [31:0] ejQ[$];
  int          checks = 0;
  int          errors = 0;
  logic        prevRingV = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; ring/eject expectations refer to the following cycle.
  task automatic cyc(input logic rs, input logic rv, input logic [31:0] rd,
                     input logic ie, input logic [31:0] id, input logic er, input logic th,
                     input logic chkAll, input logic pop, input logic starve, input logic zero,
                     input logic expRv, input logic [31:0] expRd,
                     input logic expEj, input logic [31:0] expEd);
    ctl_t c;
    @(posedge clk);
    #1;
    rst           = rs;
    bus.iRingVld  = rv;
    bus.iRingDat  = rd;
    bus.iInjEmpty = ie;
    bus.iInjDat   = id;
    bus.iEjRdy    = er;
    bus.iThrottle = th;
    c.chkAll = chkAll;
    c.pop    = pop;
    c.starve = starve;
    c.ringV  = prevRingV;
    c.zero   = zero;
    ctlQ.push_back(c);
    prevRingV = expRv;
    if (expRv) ringQ.push_back(expRd);
    if (expEj) ejQ.push_back(expEd);
    $display("cycle rst=%0b ringIn=%0b/%h injEmpty=%0b inj=%h ejRdy=%0b thr=%0b expPop=%0b expStarve=%0b",
             rs, rv, rd, ie, id, er, th, pop, starve);
  endtask

  initial begin : monitor
    ctl_t c;
    forever begin
      @(negedge clk);
      if (ctlQ.size() > 0) begin
        c = ctlQ.pop_front();
        chk("oInjRdEn", {31'd0, bus.oInjRdEn}, {31'd0, c.pop});
        if (c.chkAll) begin
          chk("oStarve", {31'd0, bus.oStarve}, {31'd0, c.starve});
          chk("oRingVld", {31'd0, bus.oRingVld}, {31'd0, c.ringV});
          if (c.zero) begin
            chk("rstRingDat", bus.oRingDat, 32'd0);
            chk("rstEjVld", {31'd0, bus.oEjVld}, 32'd0);
            chk("rstEjDat", bus.oEjDat, 32'd0);
          end
        end
      end
      if (bus.oRingVld === 1'b1) begin
        if (ringQ.size() == 0) chk("ringUnexpected", {31'd0, bus.oRingVld}, 32'd0);
        else chk("oRingDat", bus.oRingDat, ringQ.pop_front());
      end
      if (bus.oEjVld === 1'b1 && bus.iEjRdy === 1'b1) begin
        if (ejQ.size() == 0) chk("ejUnexpected", {31'd0, bus.oEjVld}, 32'd0);
        else chk("oEjDat", bus.oEjDat, ejQ.pop_front());
      end
    end
  end

  initial begin : stimulus
    bus.iRingVld  = 1'b0;
    bus.iRingDat  = '0;
    bus.iInjEmpty = 1'b1;
    bus.iInjDat   = '0;
    bus.iEjRdy    = 1'b0;
    bus.iThrottle = 1'b0;
    //   rs rv rd  ie id  er th | all pop stv zero | expRing | expEj
    cyc(0, 0, 0,  0, FA, 0, 0,   0,  0,  0,  0,    0, 0,     0, 0);
    cyc(0, 0, 0,  0, FA, 0, 0,   1,  0,  0,  1,    0, 0,     0, 0);
    // Idle ring: FIFO head goes straight out.
    cyc(1, 0, 0,  0, FA, 0, 0,   1,  1,  0,  0,    1, FA,    0, 0);
    // Own flit ejected, FIFO head takes the freed slot.
    cyc(1, 1, FB, 0, FE, 0, 0,   1,  1,  0,  0,    1, FE,    1, FB);
    // Ejection register busy: matching flit deflected, no injection.
    cyc(1, 1, FC, 0, FF, 0, 0,   1,  0,  0,  0,    1, FC,    0, 0);
    cyc(1, 0, 0,  1, 0,  1, 0,   1,  0,  0,  0,    0, 0,     0, 0);
    // Throttled and not starved: hold off.
    cyc(1, 0, 0,  0, FF, 0, 1,   1,  0,  0,  0,    0, 0,     0, 0);
    cyc(1, 0, 0,  1, 0,  0, 0,   1,  0,  0,  0,    0, 0,     0, 0);
    // Continuous ring traffic blocks injection for 8 cycles.
    for (int i = 0; i < 8; i++)
      cyc(1, 1, FD, 0, FF, 0, 0, 1,  0,  0,  0,    1, FD,    0, 0);
    cyc(1, 1, FD, 0, FF, 0, 1,   1,  0,  1,  0,    1, FD,    0, 0);
    // Starved stop ignores throttle once the slot frees.
    cyc(1, 0, 0,  0, FF, 0, 1,   1,  1,  1,  0,    1, FF,    0, 0);
    cyc(1, 0, 0,  1, 0,  0, 0,   1,  0,  0,  0,    0, 0,     0, 0);
    // Fill both registers, then reset mid-stream.
    cyc(1, 1, FB, 0, FA, 0, 0,   1,  1,  0,  0,    1, FA,    1, FB);
    cyc(1, 1, FD, 1, 0,  0, 0,   1,  0,  0,  0,    1, FD,    0, 0);
    cyc(0, 1, FD, 0, FA, 0, 0,   1,  0,  0,  0,    0, 0,     0, 0);
    ejQ.delete();
    cyc(1, 0, 0,  1, 0,  0, 0,   1,  0,  0,  1,    0, 0,     0, 0);
    cyc(1, 0, 0,  1, 0,  0, 0,   1,  0,  0,  0,    0, 0,     0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("ringQDrained", ringQ.size(), 32'd0);
    chk("ejQDrained", ejQ.size(), 32'd0);
    chk("ctlQDrained", ctlQ.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
